pc_stat_ctrl: RTL and testbench
===============================

Name: pc_stat_ctrl

Overview:
- Architectural PC register and Y86-64 status controller for the sequential core; sits between pc_update (consumes pc_new) and fetch (drives PC).
- Decides each cycle whether the current instruction retires, gates architectural writes via commit, and freezes the machine on HLT/ADR/INS.
- Supports free-run and single-step modes; keeps cycle and retired-instruction counters for debug.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset and on restart.
- CNT_W, 64, width of cycle_count and instr_count.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  leave IDLE; sampled only in IDLE.
- step_mode  in  1  1 = single-step, 0 = free-run; sampled on leaving IDLE.
- step_req  in  1  one-cycle pulse; retires one instruction in STEP_WAIT.
- restart  in  1  synchronous return to IDLE with PC=RESET_PC.
- icode  in  4  current instruction code from fetch.
- instr_valid  in  1  fetch decode-valid flag.
- imem_error  in  1  instruction fetch address out of range.
- dmem_error  in  1  data memory access out of range.
- pc_new  in  64  next PC from pc_update.
- PC  out  64  current PC to fetch.
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- commit  out  1  combinational; regfile/dmem/CC write enable this cycle.
- halted  out  1  high in STOP.
- cycle_count  out  CNT_W  active cycles.
- instr_count  out  CNT_W  retired instructions.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, PC=RESET_PC, stat=1, counters=0, halted=0; commit=0 while rst_n=0.
- States: IDLE, RUN, STEP_WAIT, STOP.
- IDLE: start=1 -> RUN if step_mode=0, else STEP_WAIT. No commit, counters hold.
- adv = (state==RUN) | (state==STEP_WAIT & step_req).
- Fault classification, priority high to low:
  - imem_error -> ADR.
  - !instr_valid -> INS.
  - dmem_error -> ADR.
  - icode==4'h0 -> HLT.
  - else none.
- commit = adv & no fault, or adv & HLT; a HLT instruction is counted as retired.
- On adv with no fault: PC<=pc_new, instr_count+1; remain in RUN or STEP_WAIT.
- On adv with HLT: instr_count+1, PC unchanged (points at halt), stat<=2, state<=STOP.
- On adv with ADR/INS: commit=0, PC unchanged (faulting instruction), instr_count unchanged, stat<=3/4, state<=STOP.
- cycle_count increments every cycle in RUN or STEP_WAIT, whether or not step_req is present; holds in IDLE and STOP.
- Counters wrap modulo 2^CNT_W.
- STOP: all outputs hold, halted=1, start and step_req ignored.
- restart=1 from any state overrides everything that cycle: state<=IDLE, PC<=RESET_PC, stat<=1, counters<=0, commit=0.
- step_mode is ignored after leaving IDLE.
- step_req held high in STEP_WAIT retires one instruction per cycle, with no edge detection.
- PC and stat are registered and visible one cycle after the retiring edge.

Test Plan:
- Reset, start=1 step_mode=0, icode=6 valid, pc_new=PC+2 for 5 cycles -> PC=0x0A, instr_count=5, cycle_count=5, commit=1 each cycle.
- In RUN at PC=0x14, icode=0 -> commit=1 that cycle; next cycle stat=2, halted=1, PC=0x14, instr_count+1; further start/step_req change nothing.
- In RUN, instr_valid=0 with imem_error=1 at the same time -> stat=3 (ADR wins), commit=0, PC and instr_count unchanged.
- Step mode: 4 idle cycles then 2 step_req pulses -> cycle_count=6, instr_count=2, PC advanced twice.
- CNT_W=4, run 17 valid instructions -> instr_count=1 (wrapped).
- Assert rst_n=0 mid-RUN between clock edges -> PC=RESET_PC, stat=1, counters=0 immediately; restart from STOP -> IDLE, halted=0 next cycle.

Source files
------------

// File: rtl/pc_stat_ctrl.sv
// Architectural PC register and Y86-64 status controller for the sequential core.
// Decides retirement each cycle, gates architectural writes and freezes on HLT/ADR/INS.
module pc_stat_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step_req,
  input  logic             restart,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             dmem_error,
  input  logic [63:0]      pc_new,
  output logic [63:0]      PC,
  output logic [2:0]       stat,
  output logic             commit,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStepWait,
    StStop
  } state_e;

  localparam logic [2:0] StatAok = 3'd1;
  localparam logic [2:0] StatHlt = 3'd2;
  localparam logic [2:0] StatAdr = 3'd3;
  localparam logic [2:0] StatIns = 3'd4;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [63:0]      pc_q, pc_d;
  logic [2:0]       stat_q, stat_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instr_q, instr_d;

  logic       adv;
  logic       retire_ok;
  logic       is_halt;
  logic [2:0] fault_stat;

  // Fault priority: imem_error, then invalid decode, then dmem_error.
  always_comb begin
    adv        = (state_q == StRun) | ((state_q == StStepWait) & step_req);
    retire_ok  = adv & ~imem_error & instr_valid & ~dmem_error;
    is_halt    = retire_ok & (icode == 4'h0);
    fault_stat = StatAdr;
    if (!imem_error && !instr_valid) begin
      fault_stat = StatIns;
    end
  end

  // A HLT instruction retires and commits; restart suppresses all writes.
  assign commit = retire_ok & ~restart;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stat_d  = stat_q;
    cycle_d = cycle_q;
    instr_d = instr_q;
    if (restart) begin
      state_d = StIdle;
      pc_d    = RESET_PC;
      stat_d  = StatAok;
      cycle_d = '0;
      instr_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_d = step_mode ? StStepWait : StRun;
          end
        end
        StRun, StStepWait: begin
          cycle_d = cycle_q + CntOne;
          if (adv) begin
            if (retire_ok) begin
              instr_d = instr_q + CntOne;
              if (is_halt) begin
                stat_d  = StatHlt;
                state_d = StStop;
              end else begin
                pc_d = pc_new;
              end
            end else begin
              // Faulting instruction: PC keeps pointing at it.
              stat_d  = fault_stat;
              state_d = StStop;
            end
          end
        end
        StStop: begin
          state_d = StStop;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      stat_q  <= StatAok;
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stat_q  <= stat_d;
      cycle_q <= cycle_d;
      instr_q <= instr_d;
    end
  end

  assign PC          = pc_q;
  assign stat        = stat_q;
  assign halted      = (state_q == StStop);
  assign cycle_count = cycle_q;
  assign instr_count = instr_q;

endmodule

// File: tb/tb_pc_stat_ctrl.sv
// Self-checking bench for pc_stat_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural model of the retire/fault rules.
module tb_pc_stat_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        step_mode;
  logic        step_req;
  logic        restart;
  logic [3:0]  icode;
  logic        instr_valid;
  logic        imem_error;
  logic        dmem_error;
  logic [63:0] pc_new;

  logic [63:0] pc_o;
  logic [2:0]  stat_o;
  logic        commit_o;
  logic        halted_o;
  logic [63:0] cyc_o;
  logic [63:0] ins_o;

  logic [63:0] pc2;
  logic [2:0]  stat2;
  logic        commit2;
  logic        halted2;
  logic [3:0]  cyc2;
  logic [3:0]  ins2;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: activity flags, not a state encoding.
  bit          m_idle;
  bit          m_active;
  bit          m_stop;
  bit          m_stepmode;
  logic [63:0] m_pc;
  logic [2:0]  m_stat;
  logic [63:0] m_cyc;
  logic [63:0] m_ins;

  pc_stat_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode), .step_req(step_req),
    .restart(restart), .icode(icode), .instr_valid(instr_valid), .imem_error(imem_error),
    .dmem_error(dmem_error), .pc_new(pc_new), .PC(pc_o), .stat(stat_o), .commit(commit_o),
    .halted(halted_o), .cycle_count(cyc_o), .instr_count(ins_o)
  );

  pc_stat_ctrl #(.CNT_W(4)) dut_w4 (
    .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode), .step_req(step_req),
    .restart(restart), .icode(icode), .instr_valid(instr_valid), .imem_error(imem_error),
    .dmem_error(dmem_error), .pc_new(pc_new), .PC(pc2), .stat(stat2), .commit(commit2),
    .halted(halted2), .cycle_count(cyc2), .instr_count(ins2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_idle = 1; m_active = 0; m_stop = 0; m_stepmode = 0;
    m_pc = 64'h0; m_stat = 3'd1; m_cyc = 0; m_ins = 0;
  endtask

  function automatic bit model_commit();
    bit adv;
    adv = m_active && (!m_stepmode || step_req);
    return rst_n && !restart && adv && !imem_error && instr_valid && !dmem_error;
  endfunction

  task automatic model_update();
    if (!rst_n || restart) begin
      model_reset();
    end else if (m_idle) begin
      if (start) begin
        m_idle = 0; m_active = 1; m_stepmode = step_mode;
      end
    end else if (m_active) begin
      m_cyc = m_cyc + 1;
      if (!m_stepmode || step_req) begin
        if (imem_error)        begin m_stat = 3; m_active = 0; m_stop = 1; end
        else if (!instr_valid) begin m_stat = 4; m_active = 0; m_stop = 1; end
        else if (dmem_error)   begin m_stat = 3; m_active = 0; m_stop = 1; end
        else if (icode == 0)   begin m_ins = m_ins + 1; m_stat = 2; m_active = 0; m_stop = 1; end
        else                   begin m_ins = m_ins + 1; m_pc = pc_new; end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    start = 0; step_mode = 0; step_req = 0; restart = 0; icode = 4'h6;
    instr_valid = 1; imem_error = 0; dmem_error = 0; pc_new = 64'h0;
  endtask

  task automatic do_restart();
    clear_inputs();
    restart = 1;
    tick();
    restart = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    model_reset();
    tick(); tick();
    n_checks++; if (pc_o !== 64'h0) begin n_errors++; $display("FAIL reset_pc: got %h want 0", pc_o); end
    n_checks++; if (stat_o !== 3'd1) begin n_errors++; $display("FAIL reset_stat: got %0d want 1", stat_o); end
    n_checks++; if (halted_o !== 1'b0) begin n_errors++; $display("FAIL reset_halted: got %b want 0", halted_o); end
    n_checks++; if (cyc_o !== 64'h0 || ins_o !== 64'h0) begin n_errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0", cyc_o, ins_o); end
    n_checks++; if (commit_o !== 1'b0) begin n_errors++; $display("FAIL reset_commit: got %b want 0", commit_o); end
    rst_n = 1;
    tick();
  endtask

  task automatic test_run();
    start = 1; step_mode = 0; icode = 4'h6; instr_valid = 1; pc_new = m_pc + 2;
    #1;
    n_checks++; if (commit_o !== 1'b0) begin n_errors++; $display("FAIL idle_commit: got %b want 0", commit_o); end
    tick();
    start = 0;
    for (int i = 0; i < 5; i++) begin
      pc_new = m_pc + 2;
      #1;
      n_checks++; if (commit_o !== 1'b1) begin n_errors++; $display("FAIL run_commit[%0d]: got %b want 1", i, commit_o); end
      tick();
    end
    n_checks++; if (pc_o !== 64'h0A) begin n_errors++; $display("FAIL run_pc: got %h want 0a", pc_o); end
    n_checks++; if (ins_o !== 64'd5) begin n_errors++; $display("FAIL run_instr: got %0d want 5", ins_o); end
    n_checks++; if (cyc_o !== 64'd5) begin n_errors++; $display("FAIL run_cycle: got %0d want 5", cyc_o); end
  endtask

  task automatic test_halt();
    for (int i = 0; i < 5; i++) begin
      pc_new = m_pc + 2;
      tick();
    end
    n_checks++; if (pc_o !== 64'h14) begin n_errors++; $display("FAIL halt_pre_pc: got %h want 14", pc_o); end
    icode = 4'h0; pc_new = 64'h999;
    #1;
    n_checks++; if (commit_o !== 1'b1) begin n_errors++; $display("FAIL halt_commit: got %b want 1", commit_o); end
    tick();
    n_checks++; if (stat_o !== 3'd2) begin n_errors++; $display("FAIL halt_stat: got %0d want 2", stat_o); end
    n_checks++; if (halted_o !== 1'b1) begin n_errors++; $display("FAIL halt_halted: got %b want 1", halted_o); end
    n_checks++; if (pc_o !== 64'h14) begin n_errors++; $display("FAIL halt_pc: got %h want 14", pc_o); end
    n_checks++; if (ins_o !== 64'd11) begin n_errors++; $display("FAIL halt_instr: got %0d want 11", ins_o); end
    start = 1; step_req = 1; icode = 4'h6; pc_new = 64'h100;
    #1;
    n_checks++; if (commit_o !== 1'b0) begin n_errors++; $display("FAIL stop_commit: got %b want 0", commit_o); end
    repeat (3) tick();
    n_checks++; if (pc_o !== 64'h14 || stat_o !== 3'd2) begin n_errors++; $display("FAIL stop_hold: got pc %h stat %0d want 14/2", pc_o, stat_o); end
    n_checks++; if (ins_o !== 64'd11 || cyc_o !== 64'd11) begin n_errors++; $display("FAIL stop_counters: got %0d/%0d want 11/11", ins_o, cyc_o); end
  endtask

  task automatic test_fault_priority();
    do_restart();
    n_checks++; if (halted_o !== 1'b0 || stat_o !== 3'd1 || pc_o !== 64'h0) begin n_errors++; $display("FAIL restart_state: got halted %b stat %0d pc %h want 0/1/0", halted_o, stat_o, pc_o); end
    n_checks++; if (ins_o !== 64'd0 || cyc_o !== 64'd0) begin n_errors++; $display("FAIL restart_counters: got %0d/%0d want 0/0", ins_o, cyc_o); end
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 2; i++) begin
      pc_new = m_pc + 2;
      tick();
    end
    instr_valid = 0; imem_error = 1; pc_new = 64'h55;
    #1;
    n_checks++; if (commit_o !== 1'b0) begin n_errors++; $display("FAIL adr_commit: got %b want 0", commit_o); end
    tick();
    n_checks++; if (stat_o !== 3'd3) begin n_errors++; $display("FAIL adr_wins: got %0d want 3", stat_o); end
    n_checks++; if (pc_o !== 64'h4 || ins_o !== 64'd2) begin n_errors++; $display("FAIL adr_hold: got pc %h instr %0d want 4/2", pc_o, ins_o); end
    do_restart();
    start = 1;
    tick();
    start = 0; instr_valid = 0; dmem_error = 1;
    #1;
    n_checks++; if (commit_o !== 1'b0) begin n_errors++; $display("FAIL ins_commit: got %b want 0", commit_o); end
    tick();
    n_checks++; if (stat_o !== 3'd4) begin n_errors++; $display("FAIL ins_over_dmem: got %0d want 4", stat_o); end
    do_restart();
    start = 1;
    tick();
    start = 0; dmem_error = 1;
    tick();
    n_checks++; if (stat_o !== 3'd3 || ins_o !== 64'd0) begin n_errors++; $display("FAIL dmem_adr: got stat %0d instr %0d want 3/0", stat_o, ins_o); end
  endtask

  task automatic test_step();
    do_restart();
    start = 1; step_mode = 1;
    tick();
    start = 0; step_mode = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (commit_o !== 1'b0) begin n_errors++; $display("FAIL step_wait_commit[%0d]: got %b want 0", i, commit_o); end
      tick();
    end
    n_checks++; if (cyc_o !== 64'd4 || pc_o !== 64'h0) begin n_errors++; $display("FAIL step_wait: got cyc %0d pc %h want 4/0", cyc_o, pc_o); end
    step_req = 1;
    for (int i = 0; i < 2; i++) begin
      pc_new = m_pc + 2;
      #1;
      n_checks++; if (commit_o !== 1'b1) begin n_errors++; $display("FAIL step_commit[%0d]: got %b want 1", i, commit_o); end
      tick();
    end
    step_req = 0;
    n_checks++; if (cyc_o !== 64'd6 || ins_o !== 64'd2 || pc_o !== 64'h4) begin n_errors++; $display("FAIL step_result: got cyc %0d ins %0d pc %h want 6/2/4", cyc_o, ins_o, pc_o); end
    pc_new = 64'h77;
    tick();
    n_checks++; if (pc_o !== 64'h4 || cyc_o !== 64'd7) begin n_errors++; $display("FAIL step_idle: got pc %h cyc %0d want 4/7", pc_o, cyc_o); end
  endtask

  task automatic test_wrap();
    do_restart();
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 17; i++) begin
      pc_new = m_pc + 2;
      tick();
    end
    n_checks++; if (ins2 !== 4'd1 || cyc2 !== 4'd1) begin n_errors++; $display("FAIL wrap_w4: got ins %0d cyc %0d want 1/1", ins2, cyc2); end
    n_checks++; if (ins_o !== 64'd17) begin n_errors++; $display("FAIL wrap_w64: got %0d want 17", ins_o); end
  endtask

  task automatic test_async_reset();
    do_restart();
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 3; i++) begin
      pc_new = m_pc + 2;
      tick();
    end
    #2;
    rst_n = 0;
    model_reset();
    #1;
    n_checks++; if (pc_o !== 64'h0 || stat_o !== 3'd1) begin n_errors++; $display("FAIL async_pc_stat: got pc %h stat %0d want 0/1", pc_o, stat_o); end
    n_checks++; if (cyc_o !== 64'd0 || ins_o !== 64'd0) begin n_errors++; $display("FAIL async_counters: got %0d/%0d want 0/0", cyc_o, ins_o); end
    n_checks++; if (commit_o !== 1'b0) begin n_errors++; $display("FAIL async_commit: got %b want 0", commit_o); end
    @(negedge clk);
    rst_n = 1;
    start = 1; icode = 4'h0;
    tick();
    start = 0;
    tick();
    n_checks++; if (halted_o !== 1'b1) begin n_errors++; $display("FAIL stop_reached: got %b want 1", halted_o); end
    restart = 1;
    #1;
    n_checks++; if (commit_o !== 1'b0) begin n_errors++; $display("FAIL restart_commit: got %b want 0", commit_o); end
    tick();
    restart = 0;
    n_checks++; if (halted_o !== 1'b0 || stat_o !== 3'd1 || ins_o !== 64'd0) begin n_errors++; $display("FAIL restart_from_stop: got halted %b stat %0d ins %0d want 0/1/0", halted_o, stat_o, ins_o); end
    tick();
    n_checks++; if (cyc_o !== 64'd0) begin n_errors++; $display("FAIL restart_idle_cycle: got %0d want 0", cyc_o); end
  endtask

  task automatic test_random();
    do_restart();
    for (int i = 0; i < 400; i++) begin
      restart     = ($urandom_range(0, 39) == 0);
      start       = ($urandom_range(0, 3) == 0);
      step_mode   = 1'($urandom);
      step_req    = 1'($urandom);
      icode       = ($urandom_range(0, 15) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      instr_valid = ($urandom_range(0, 19) != 0);
      imem_error  = ($urandom_range(0, 24) == 0);
      dmem_error  = ($urandom_range(0, 24) == 0);
      pc_new      = {$urandom, $urandom};
      #1;
      n_checks++; if (commit_o !== model_commit() || commit2 !== model_commit()) begin n_errors++; $display("FAIL rand_commit[%0d]: got %b/%b want %b", i, commit_o, commit2, model_commit()); end
      tick();
      n_checks++; if (pc_o !== m_pc || pc2 !== m_pc) begin n_errors++; $display("FAIL rand_pc[%0d]: got %h/%h want %h", i, pc_o, pc2, m_pc); end
      n_checks++; if (stat_o !== m_stat || stat2 !== m_stat) begin n_errors++; $display("FAIL rand_stat[%0d]: got %0d/%0d want %0d", i, stat_o, stat2, m_stat); end
      n_checks++; if (halted_o !== m_stop || halted2 !== m_stop) begin n_errors++; $display("FAIL rand_halted[%0d]: got %b/%b want %b", i, halted_o, halted2, m_stop); end
      n_checks++; if (cyc_o !== m_cyc || cyc2 !== m_cyc[3:0]) begin n_errors++; $display("FAIL rand_cycle[%0d]: got %0d/%0d want %0d", i, cyc_o, cyc2, m_cyc); end
      n_checks++; if (ins_o !== m_ins || ins2 !== m_ins[3:0]) begin n_errors++; $display("FAIL rand_instr[%0d]: got %0d/%0d want %0d", i, ins_o, ins2, m_ins); end
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_halt();
    test_fault_priority();
    test_step();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
